// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common-data-bus arbiter slice: tag width and
// the encoding of which producer owns a broadcast.
package cdb_arbiter_pkg;

  localparam int ROB_SIZE_WIDTH = 4;

  typedef enum logic {
    CDB_SRC_ALU = 1'b0,
    CDB_SRC_LSB = 1'b1
  } cdb_src_e;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer inputs, backpressure and CDB broadcast bundled as one port.
// The arbiter takes the slave side; the producer/snooper environment takes master.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int ROB_W  = ROB_SIZE_WIDTH,
  parameter int DATA_W = 32
);

  logic              alu_valid;
  logic [ROB_W-1:0]  alu_rob_id;
  logic [DATA_W-1:0] alu_value;
  logic              alu_full;
  logic              lsb_valid;
  logic [ROB_W-1:0]  lsb_rob_id;
  logic [DATA_W-1:0] lsb_value;
  logic              lsb_full;
  logic              cdb_valid;
  logic [ROB_W-1:0]  cdb_rob_id;
  logic [DATA_W-1:0] cdb_value;
  logic              cdb_src;
  logic              overflow_err;

  modport master (
    output alu_valid, alu_rob_id, alu_value, lsb_valid, lsb_rob_id, lsb_value,
    input  alu_full, lsb_full, cdb_valid, cdb_rob_id, cdb_value, cdb_src, overflow_err
  );

  modport slave (
    input  alu_valid, alu_rob_id, alu_value, lsb_valid, lsb_rob_id, lsb_value,
    output alu_full, lsb_full, cdb_valid, cdb_rob_id, cdb_value, cdb_src, overflow_err
  );

endinterface

// File: rtl/cdb_arbiter_result_fifo.sv
// Small per-producer result queue. Head is read combinationally so the
// arbiter can pick it in the same cycle; a push while full is dropped unless a pop frees a slot.
module result_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 36
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_W'(DEPTH));
  assign count  = count_q;
  assign dout   = mem_q[rd_ptr_q];
  assign accept = push && (!full || pop);

  // DEPTH is a power of two, so pointer wrap is the natural overflow of PTR_W bits
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(accept);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(accept) - CNT_W'(pop);
    if (accept) begin
      mem_d[wr_ptr_q] = din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin scheduler of the shared CDB between the ALU and LSB result paths,
// with per-source queues, same-cycle bypass when a queue is empty, and one registered broadcast.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int ROB_W  = ROB_SIZE_WIDTH,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         rob_clear,
  cdb_arbiter_if.slave bus
);

  localparam int WIDTH = ROB_W + DATA_W;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // index 0 is the ALU path, index 1 the LSB path, matching cdb_src_e
  logic [WIDTH-1:0] in_entry   [2];
  logic             in_valid   [2];
  logic [WIDTH-1:0] head       [2];
  logic [WIDTH-1:0] cand_entry [2];
  logic             empty      [2];
  logic             full       [2];
  logic [CNT_W-1:0] count      [2];
  logic             cand       [2];
  logic             grant      [2];
  logic             push       [2];
  logic             pop        [2];
  logic             ovf_hit    [2];

  logic              cdb_valid_q,  cdb_valid_d;
  logic [ROB_W-1:0]  cdb_rob_id_q, cdb_rob_id_d;
  logic [DATA_W-1:0] cdb_value_q,  cdb_value_d;
  cdb_src_e          cdb_src_q,    cdb_src_d;
  cdb_src_e          rr_last_q,    rr_last_d;
  logic              ovf_q,        ovf_d;

  assign in_valid[0] = bus.alu_valid;
  assign in_entry[0] = {bus.alu_rob_id, bus.alu_value};
  assign in_valid[1] = bus.lsb_valid;
  assign in_entry[1] = {bus.lsb_rob_id, bus.lsb_value};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      // Bypass only from an empty queue keeps each producer's results in order
      assign cand[gi]       = !empty[gi] || in_valid[gi];
      assign cand_entry[gi] = empty[gi] ? in_entry[gi] : head[gi];
      assign pop[gi]        = rdy && grant[gi] && !empty[gi];
      assign push[gi]       = rdy && in_valid[gi] && !(grant[gi] && empty[gi]);
      assign ovf_hit[gi]    = push[gi] && !pop[gi] && (count[gi] == CNT_W'(DEPTH));

      result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
      ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (rob_clear),
        .push  (push[gi]),
        .pop   (pop[gi]),
        .din   (in_entry[gi]),
        .dout  (head[gi]),
        .empty (empty[gi]),
        .full  (full[gi]),
        .count (count[gi])
      );
    end
  endgenerate

  always_comb begin
    grant[0] = cand[0];
    grant[1] = cand[1];
    if (cand[0] && cand[1]) begin
      grant[0] = (rr_last_q == CDB_SRC_LSB);
      grant[1] = (rr_last_q == CDB_SRC_ALU);
    end
  end

  always_comb begin
    cdb_valid_d  = 1'b0;
    cdb_rob_id_d = cdb_rob_id_q;
    cdb_value_d  = cdb_value_q;
    cdb_src_d    = cdb_src_q;
    rr_last_d    = rr_last_q;
    ovf_d        = ovf_q || ovf_hit[0] || ovf_hit[1];
    if (grant[0] || grant[1]) begin
      cdb_valid_d                 = 1'b1;
      {cdb_rob_id_d, cdb_value_d} = grant[1] ? cand_entry[1] : cand_entry[0];
      cdb_src_d                   = grant[1] ? CDB_SRC_LSB : CDB_SRC_ALU;
      rr_last_d                   = cdb_src_d;
    end
  end

  // overflow_err is a verification aid and survives a misprediction flush
  always_ff @(posedge clk) begin
    if (rst || rob_clear) begin
      cdb_valid_q  <= 1'b0;
      cdb_rob_id_q <= '0;
      cdb_value_q  <= '0;
      cdb_src_q    <= CDB_SRC_ALU;
      rr_last_q    <= CDB_SRC_LSB;
      if (rst) begin
        ovf_q <= 1'b0;
      end
    end else if (rdy) begin
      cdb_valid_q  <= cdb_valid_d;
      cdb_rob_id_q <= cdb_rob_id_d;
      cdb_value_q  <= cdb_value_d;
      cdb_src_q    <= cdb_src_d;
      rr_last_q    <= rr_last_d;
      ovf_q        <= ovf_d;
    end
  end

  assign bus.alu_full     = full[0];
  assign bus.lsb_full     = full[1];
  assign bus.cdb_valid    = cdb_valid_q;
  assign bus.cdb_rob_id   = cdb_rob_id_q;
  assign bus.cdb_value    = cdb_value_q;
  assign bus.cdb_src      = cdb_src_q;
  assign bus.overflow_err = ovf_q;

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Schedules the single common data bus (CDB) shared by two result producers: the ALU path (RS result) and the LSB (load/store results).
- Each producer pushes results into its own small FIFO.
- The arbiter picks one head per cycle, round-robin, and drives one registered broadcast that RS, LSB and RoB all snoop.
- Provides per-producer backpressure, flush on misprediction (rob_clear), and a sticky overflow flag for verification.

Parameters:
- ROB_W, 4, width of RoB tag (equals `ROB_SIZE_WIDTH).
- DATA_W, 32, width of broadcast value.
- DEPTH, 2, entries per producer FIFO (power of two, >=2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global ready; low freezes all state.
- rob_clear  in  1  flush; synchronous, same priority as rst.
- alu_valid  in  1  ALU result present this cycle.
- alu_rob_id  in  ROB_W  tag of ALU result.
- alu_value  in  DATA_W  ALU result value.
- alu_full  out  1  ALU FIFO full; producer must not push.
- lsb_valid  in  1  LSB result present this cycle.
- lsb_rob_id  in  ROB_W  tag of LSB result.
- lsb_value  in  DATA_W  LSB result value.
- lsb_full  out  1  LSB FIFO full.
- cdb_valid  out  1  broadcast valid (registered).
- cdb_rob_id  out  ROB_W  broadcast tag (registered).
- cdb_value  out  DATA_W  broadcast value (registered).
- cdb_src  out  1  0 = ALU, 1 = LSB (registered; debug/verification).
- overflow_err  out  1  sticky; set on a push while full.

Behaviour:
- Reset / rob_clear at posedge:
  - Both FIFOs emptied (pointers and counts to 0).
  - cdb_valid=0, cdb_rob_id=0, cdb_value=0, cdb_src=0.
  - rr_last=1, so the ALU wins the first contention.
  - overflow_err cleared by rst only, not by rob_clear.
  - Inputs presented in the same cycle are discarded.
- rdy=0: no register changes; all outputs hold their values. Inputs are ignored (producers are frozen by the same rdy).
- Candidate per source: the FIFO head if the FIFO is non-empty; otherwise the live input (bypass) if valid. Bypass exists only when the FIFO is empty, which preserves per-source order.
- Grant:
  - Exactly one candidate: grant it.
  - Both candidates: grant the source != rr_last.
  - rr_last updates to the granted source on every grant.
  - No candidate: cdb_valid<=0 and rr_last unchanged.
- Output register: at posedge, if a grant occurs, cdb_valid<=1 and cdb_rob_id/cdb_value/cdb_src take the granted entry. Latency is 1 cycle (input in cycle t, broadcast in t+1) when the source queue is empty and the source wins.
- FIFO update per source, each cycle:
  - Granted head: pop.
  - Granted bypass: no push, no pop.
  - Valid input not bypassed (FIFO non-empty, or lost arbitration): push.
  - Simultaneous push and pop: count unchanged, head advances.
  - Pointers wrap modulo DEPTH. count range is 0..DEPTH.
- full = (count == DEPTH), combinational from the registered count.
  - Push when count == DEPTH with no same-cycle pop: entry dropped, overflow_err<=1.
  - Push when full with a same-cycle pop: accepted; no error.
- Starvation bound: a queued head waits at most 1 cycle under continuous contention.
- No tag or value checking; duplicate tags are passed through unchanged.

Decomposition:
- Shared config header holds ROB_SIZE_WIDTH and the CDB source encodings CDB_SRC_ALU=0 and CDB_SRC_LSB=1.
- One sub-module, result_fifo, instantiated twice.
  - Parameters: DEPTH, WIDTH = ROB_W + DATA_W.
  - Ports: push, pop, din, dout, empty, full, count, flush.
- Arbitration and the output register live in the top module.

Test Plan:
- Single ALU result: alu_valid=1, tag 3, value 0x11 in cycle 0 → cdb_valid=1, rob_id 3, value 0x11, src 0 in cycle 1. cdb_valid=0 in cycle 2.
- Contention after reset: ALU (tag 1, 0xA) and LSB (tag 2, 0xB) both valid in cycle 0 → cycle 1 broadcasts tag 1 (ALU); cycle 2 broadcasts tag 2 (LSB). LSB count peaks at 1.
- Fill and backpressure:
  - ALU pushes tags 4, 5, 6 on consecutive cycles while LSB streams continuously.
  - Broadcasts alternate; ALU order stays 4, 5, 6.
  - alu_full asserts when count reaches 2.
  - A forced push while full sets overflow_err=1; it stays set after rob_clear.
- Flush: queue 2 LSB entries, assert rob_clear in cycle 5 with a new alu_valid → cdb_valid=0 in cycle 6, both full flags 0, no stale tag broadcast afterwards.
- rdy stall: entry queued, rdy=0 for 3 cycles → outputs and counts frozen; after rdy=1, the queued entry broadcasts next cycle exactly once.
- Push/pop at full: LSB count=2, its head is granted, and a new LSB input arrives in the same cycle → accepted, count stays 2, no overflow_err.
